regfile_write_bank: RTL and testbench
=====================================

Name: regfile_write_bank

Overview:
- Write side of the 32 x 64-bit register file.
- A 5:32 write-address decoder, gated by the write enable, drives 32 rows of 64 D flip-flops.
- All 32 register contents are exported as one packed 32x64 bus. This bus feeds the 64-bit, 32:1 read-port selectors used for both read ports.
- Register 31 is the architectural zero register (XZR). It is never written and always reads 0.

Parameters:
- NUM_REGS, 32: number of registers. Fixed by the 5-bit address.
- WIDTH, 64: bits per register.
- ZERO_REG, 31: index of the hardwired-zero register.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset; clears all registers.
- RegWrite  input  1  write enable from the control unit.
- WriteRegister  input  5  destination register index.
- WriteData  input  64  data to write.
- regs  output  [31:0][63:0]  packed contents of all registers; regs[i] is register i. Feeds the read-port selectors.
- wr_onehot  output  32  registered one-hot of the register written on the last edge; all zero if no write occurred. Used for debug and verification.

Behaviour:
- Clocking: single clock domain; every state element is a rising-edge flip-flop.
- reset is sampled on the rising edge, synchronous and active-high:
  - While reset=1 at an edge, all regs[i] are set to 64'h0 and wr_onehot to 32'h0, regardless of RegWrite, WriteRegister or WriteData.
  - Reset asserted in the same cycle as a write: reset wins and the write is discarded.
  - Reset mid-sequence: all prior writes are lost; contents are 0 from the next cycle.
- Decoder: dec[k] = RegWrite & (WriteRegister == k), for k = 0..31. The decoder is combinational, with exactly zero or one bit high.
- Write enable per row: en[k] = dec[k] & (k != ZERO_REG).
- Register update, when reset=0, at each rising edge:
  - A row with en[k]=1 loads WriteData.
  - A row with en[k]=0 holds its value. Hold is implemented as a 2:1 select between the current value and WriteData.
- Latency: a write presented in cycle N is visible on regs during cycle N+1, after the edge. There is no same-cycle bypass from WriteData to regs; any forwarding belongs outside this block.
- Zero register:
  - regs[31] is constant 64'h0 in all cycles, including before the first reset.
  - A write to 31 is silently dropped and wr_onehot stays 32'h0 for that edge.
- wr_onehot at each non-reset edge is loaded with en[31:0] (bit 31 is always 0).
- RegWrite=0: no register changes, and wr_onehot is 0 after the edge.
- Multiple back-to-back writes to the same register: the last write wins; each write takes effect at its own edge.
- Before the first reset, regs[0..30] are undefined (X in simulation). After any reset they are 0.
- Output width rule: regs is indexed [register][bit], matching the read-selector input ordering. No transposition is done here; the read selector handles bit-slicing.

Test Plan:
- Reset clears state: write 64'hDEADBEEF_CAFEF00D to registers 0..30 one per cycle, then hold reset=1 for one edge -> every regs[i] == 0 and wr_onehot == 0 the following cycle.
- Single write and latency: RegWrite=1, WriteRegister=5, WriteData=64'h0000010204080001 -> regs[5] is unchanged before the edge, equals that value after the edge, wr_onehot == 32'h00000020, and all other rows are unchanged.
- Zero register: RegWrite=1, WriteRegister=31, WriteData=64'hFFFFFFFFFFFFFFFF -> regs[31] == 0 and wr_onehot == 0, with no other row modified.
- Enable low: RegWrite=0, WriteRegister=7, WriteData=64'h1234 -> regs[7] keeps its prior value and wr_onehot == 0.
- Full sweep through the read selector: write i*64'h0000010204080001 to register i for i = 0..30, then drive select = 0..31 on the read selector -> out == i*64'h0000010204080001 for i < 31, and out == 0 for select = 31.
- Reset collision: reset=1 and RegWrite=1, WriteRegister=3, WriteData=64'hAA in the same cycle -> regs[3] == 0 after the edge. Then write 64'h55 to register 3 with reset=0 -> regs[3] == 64'h55 one cycle later.

Source files
------------

// File: rtl/regfile_write_bank.sv
`default_nettype none
// ============================================================================
// Module      : regfile_write_bank
// Description : Write side of the 32 x 64-bit register file. A gated 5:32
//               write-address decoder drives one row of flops per register.
//               Register ZERO_REG is hardwired to zero. All rows are exported
//               as one packed [register][bit] bus for the read selectors.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_write_bank #(
  parameter int NUM_REGS = 32,
  parameter int WIDTH    = 64,
  parameter int ZERO_REG = 31
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               RegWrite,
  input  logic [$clog2(NUM_REGS)-1:0]        WriteRegister,
  input  logic [WIDTH-1:0]                   WriteData,
  output logic [NUM_REGS-1:0][WIDTH-1:0]     regs,
  output logic [NUM_REGS-1:0]                wr_onehot
);

  localparam int c_ADDR_W = $clog2(NUM_REGS);

  logic [NUM_REGS-1:0] w_dec;
  logic [NUM_REGS-1:0] w_en;
  logic [NUM_REGS-1:0] r_wr_onehot;

  // Write-address decoder gated by RegWrite; the zero register never enables.
  always_comb begin
    w_dec = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      w_dec[k] = RegWrite && (WriteRegister == c_ADDR_W'(k));
    end
    w_en           = w_dec;
    w_en[ZERO_REG] = 1'b0;
  end

  generate
    for (genvar k = 0; k < NUM_REGS; k++) begin : g_row
      if (k == ZERO_REG) begin : g_zero
        // Zero register has no storage; it is constant from time zero.
        assign regs[k] = '0;
      end else begin : g_store
        logic [WIDTH-1:0] r_row;

        // Row flop: load WriteData when enabled, otherwise recirculate.
        always_ff @(posedge clk) begin
          if (reset) begin
            r_row <= '0;
          end else begin
            r_row <= w_en[k] ? WriteData : r_row;
          end
        end

        assign regs[k] = r_row;
      end
    end
  endgenerate

  // Record which row was written on the last edge (all zero if none).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_onehot <= '0;
    end else begin
      r_wr_onehot <= w_en;
    end
  end

  assign wr_onehot = r_wr_onehot;

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_write_bank
// Description : Directed plus randomized bench for regfile_write_bank with an
//               array-based reference model of the register file.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_write_bank;

  localparam logic [63:0] c_STEP = 64'h0000010204080001;

  logic              clk = 1'b0;
  logic              reset;
  logic              RegWrite;
  logic [4:0]        WriteRegister;
  logic [63:0]       WriteData;
  logic [31:0][63:0] regs;
  logic [31:0]       wr_onehot;

  // Reference model: plain array of register values and the expected one-hot.
  logic [63:0] m_regs [0:31];
  logic [31:0] m_oh;

  int checks = 0;
  int errors = 0;

  regfile_write_bank dut (
    .clk           (clk),
    .reset         (reset),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .regs          (regs),
    .wr_onehot     (wr_onehot)
  );

  always #5 clk = ~clk;

  task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge, apply the architectural rules to the model, then settle.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 64'h0;
      m_oh = 32'h0;
    end else begin
      m_oh = 32'h0;
      if (RegWrite && WriteRegister != 5'd31) begin
        m_regs[WriteRegister] = WriteData;
        m_oh = 32'h1 << WriteRegister;
      end
    end
    #1;
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 32; i++)
      check64($sformatf("%s_reg%0d", tag, i), regs[i], m_regs[i]);
    check32($sformatf("%s_onehot", tag), wr_onehot, m_oh);
  endtask

  task automatic drive(input logic rst, input logic we, input logic [4:0] wa, input logic [63:0] wd);
    reset = rst; RegWrite = we; WriteRegister = wa; WriteData = wd;
  endtask

  initial begin
    logic [63:0] prev;
    for (int i = 0; i < 32; i++) m_regs[i] = 64'h0;
    m_oh = 32'h0;
    drive(1'b1, 1'b0, 5'd0, 64'h0);
    #1;
    check64("xzr_before_reset", regs[31], 64'h0);

    // Initial reset
    tick();
    check_all("init_reset");

    // Reset clears state after filling rows 0..30
    for (int i = 0; i < 31; i++) begin
      drive(1'b0, 1'b1, 5'(i), 64'hDEADBEEF_CAFEF00D);
      tick();
      check64($sformatf("fill_reg%0d", i), regs[i], 64'hDEADBEEF_CAFEF00D);
    end
    check32("fill_last_onehot", wr_onehot, 32'h4000_0000);
    drive(1'b1, 1'b0, 5'd0, 64'h0);
    tick();
    check_all("reset_clears");

    // Single write and latency
    drive(1'b0, 1'b0, 5'd9, 64'h77);
    tick();
    drive(1'b0, 1'b1, 5'd5, c_STEP);
    check64("latency_pre_edge", regs[5], 64'h0);
    tick();
    check64("single_write_val", regs[5], c_STEP);
    check32("single_write_onehot", wr_onehot, 32'h0000_0020);
    check_all("single_write");

    // Zero register write dropped
    drive(1'b0, 1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    check64("xzr_write_val", regs[31], 64'h0);
    check32("xzr_write_onehot", wr_onehot, 32'h0);
    check_all("xzr_write");

    // Enable low holds
    drive(1'b0, 1'b1, 5'd7, 64'hABCD);
    tick();
    prev = m_regs[7];
    drive(1'b0, 1'b0, 5'd7, 64'h1234);
    tick();
    check64("we_low_hold", regs[7], prev);
    check32("we_low_onehot", wr_onehot, 32'h0);

    // Back-to-back writes to the same register: last wins
    drive(1'b0, 1'b1, 5'd12, 64'h1111);
    tick();
    check64("b2b_first", regs[12], 64'h1111);
    drive(1'b0, 1'b1, 5'd12, 64'h2222);
    tick();
    check64("b2b_second", regs[12], 64'h2222);

    // Full sweep through a read selector
    for (int i = 0; i < 31; i++) begin
      drive(1'b0, 1'b1, 5'(i), 64'(i) * c_STEP);
      tick();
    end
    drive(1'b0, 1'b0, 5'd0, 64'h0);
    tick();
    for (int sel = 0; sel < 32; sel++) begin
      logic [4:0] s;
      s = 5'(sel);
      check64($sformatf("sweep_sel%0d", sel), regs[s], (sel < 31) ? 64'(sel) * c_STEP : 64'h0);
    end

    // Reset collides with a write
    drive(1'b1, 1'b1, 5'd3, 64'hAA);
    tick();
    check64("collision_reg3", regs[3], 64'h0);
    check32("collision_onehot", wr_onehot, 32'h0);
    drive(1'b0, 1'b1, 5'd3, 64'h55);
    tick();
    check64("post_collision_reg3", regs[3], 64'h55);
    check32("post_collision_onehot", wr_onehot, 32'h0000_0008);

    // Randomized traffic against the model
    for (int n = 0; n < 300; n++) begin
      drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
            5'($urandom_range(0, 31)), {$urandom(), $urandom()});
      tick();
      check_all($sformatf("rand%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
